inert_ctrl: RTL

Sequencer for the 16-bit SPI master when it is attached to the inertial sensor. After reset it waits for the sensor to power up, then issues a fixed three-word configuration sequence. After that, every data-ready interrupt triggers four register reads, which it assembles into a 16-bit pitch-rate word and a 16-bit Z-acceleration word. It sits between the SPI master (`wrt`/`cmd`/`done`/`rd_data`) and the balance-control logic, which consumes `ptch_rt`, `az` and `vld`.

---
 rtl/inert_pkg.sv | 52 +++++
 rtl/inert_ctrl_int_sync.sv | 23 ++
 rtl/inert_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/inert_pkg.sv
// Shared types and command constants for the inertial-sensor SPI sequencer.
package inert_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    CFG,
    CFG_WAIT,
    IDLE,
    RD,
    RD_WAIT,
    PUB
  } inert_state_t;

  // Configuration words, issued once after power-up in index order 0..2.
  localparam logic [15:0] CFG_INT_DRDY = 16'h0D02;
  localparam logic [15:0] CFG_GYRO_ODR = 16'h1160;
  localparam logic [15:0] CFG_ROUNDING = 16'h1440;
  localparam logic [1:0]  CFG_LAST_IDX = 2'd2;

  // Read register addresses, issued per data-ready burst in index order 0..3.
  localparam logic [7:0] RD_PITCH_L = 8'hA2;
  localparam logic [7:0] RD_PITCH_H = 8'hA3;
  localparam logic [7:0] RD_AZ_L    = 8'hAC;
  localparam logic [7:0] RD_AZ_H    = 8'hAD;
  localparam logic [1:0] RD_LAST_IDX = 2'd3;

  function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
    logic [15:0] c;
    c = 16'h0000;
    case (idx)
      2'd0:    c = CFG_INT_DRDY;
      2'd1:    c = CFG_GYRO_ODR;
      2'd2:    c = CFG_ROUNDING;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  // The read command's low byte is a don't-care to the sensor and is driven zero.
  function automatic logic [15:0] rd_cmd(input logic [1:0] idx);
    logic [7:0] addr;
    addr = RD_PITCH_L;
    case (idx)
      2'd0:    addr = RD_PITCH_L;
      2'd1:    addr = RD_PITCH_H;
      2'd2:    addr = RD_AZ_L;
      default: addr = RD_AZ_H;
    endcase
    return {addr, 8'h00};
  endfunction

endpackage

// File: rtl/inert_ctrl_int_sync.sv
// Two-flop synchronizer for the sensor's asynchronous data-ready line.
module int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // NOTE: non-blocking assignments make both flops sample on the same edge;
  // blocking ones would collapse the chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/inert_ctrl.sv
// Sequencer between the 16-bit SPI master and the inertial sensor: power-up
// wait, three configuration writes, then a four-byte read burst per interrupt.
module inert_ctrl
  import inert_pkg::*;
#(
  parameter logic [15:0] INIT_WAIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] az,
  output logic        vld
);

  inert_state_t state, state_nxt;
  logic [15:0]  wait_cnt;
  logic [1:0]   idx, idx_nxt;
  logic [7:0]   hold_q [4];
  logic         int_s;
  logic         cap_en;
  logic         pub_load;
  logic         rd_hi_unused;

  // Only the low byte of a read response carries register data.
  assign rd_hi_unused = ^rd_data[15:8];

  int_sync u_int_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (INT),
    .sync_out (int_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PWR_WAIT;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 16'd0;
    end else if (state == PWR_WAIT) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wrt       = 1'b0;
    cmd       = 16'h0000;
    vld       = 1'b0;
    cap_en    = 1'b0;
    pub_load  = 1'b0;

    case (state)
      PWR_WAIT: begin
        if (wait_cnt == INIT_WAIT - 16'd1) state_nxt = CFG;
      end

      CFG: begin
        wrt       = 1'b1;
        cmd       = cfg_cmd(idx);
        state_nxt = CFG_WAIT;
      end

      CFG_WAIT: begin
        if (done) begin
          if (idx == CFG_LAST_IDX) begin
            idx_nxt   = 2'd0;
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx + 2'd1;
            state_nxt = CFG;
          end
        end
      end

      IDLE: begin
        if (int_s) state_nxt = RD;
      end

      RD: begin
        wrt       = 1'b1;
        cmd       = rd_cmd(idx);
        state_nxt = RD_WAIT;
      end

      RD_WAIT: begin
        if (done) begin
          cap_en = 1'b1;
          if (idx == RD_LAST_IDX) begin
            pub_load  = 1'b1;
            state_nxt = PUB;
          end else begin
            idx_nxt   = idx + 2'd1;
            state_nxt = RD;
          end
        end
      end

      PUB: begin
        vld       = 1'b1;
        idx_nxt   = 2'd0;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = PWR_WAIT;
        idx_nxt   = 2'd0;
      end
    endcase
  end

  // NOTE: the holding bytes are reset so that a burst cut short by reset can
  // never leak stale data into a later publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hold_q[i] <= 8'h00;
    end else if (cap_en) begin
      hold_q[idx] <= rd_data[7:0];
    end
  end

  // The final byte bypasses its holding register so both words land on the
  // same edge that enters PUB, which is when vld rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch_rt <= 16'h0000;
      az      <= 16'h0000;
    end else if (pub_load) begin
      ptch_rt <= {hold_q[1], hold_q[0]};
      az      <= {rd_data[7:0], hold_q[2]};
    end
  end

endmodule
